// File: rtl/sensor_alarm_monitor.sv
// Sensor alarm monitor: samples the sensor bus, decodes an error, debounces it, and latches an alarm until software clears it.
// Latency: alarm rises DEBOUNCE edges after the sampling edge, or DEBOUNCE+1 edges when SENSOR_SYNC_EN is defined.
// Backpressure: none. clear is level-sampled and acts only in ALARM while the error is gone.
//
// Ports:
//   clk          in   rising-edge clock
//   n_rst        in   asynchronous active-low reset
//   sensors      in   [3:0] raw sensor bus
//   clear        in   alarm acknowledge
//   error_now    out  decoded error from the sampled sensors
//   alarm        out  latched, debounced alarm
//   alarm_pulse  out  one-cycle strobe on each entry to ALARM
//   err_count    out  [CNT_W-1:0] saturating count of ALARM entries
//   state        out  [1:0] 00 OK, 01 PEND, 10 ALARM
//
// Build option: define SENSOR_SYNC_EN to insert a 2-flop synchronizer ahead of the decode.

module sensor_alarm_monitor #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [3:0]       sensors,
  input  logic             clear,
  output logic             error_now,
  output logic             alarm,
  output logic             alarm_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ST_OK    = 2'b00,
    ST_PEND  = 2'b01,
    ST_ALARM = 2'b10
  } state_t;

  logic [3:0]       r_s_q;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [DW-1:0]    r_deb_cnt;
  logic [DW-1:0]    w_deb_nxt;
  logic             r_alarm;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;
  logic             w_err;
  logic             w_enter;

  // Sensor sampling
`ifdef SENSOR_SYNC_EN
  logic [3:0] r_s_meta;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_s_meta <= 4'b0000;
      r_s_q    <= 4'b0000;
    end else begin
      r_s_meta <= sensors;
      r_s_q    <= r_s_meta;
    end
  end
`else
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_s_q <= 4'b0000;
    end else begin
      r_s_q <= sensors;
    end
  end
`endif

  assign w_err = r_s_q[0] | (r_s_q[1] & (r_s_q[2] | r_s_q[3]));

  // Next-state and debounce counter
  always_comb begin
    w_state_nxt = r_state;
    w_deb_nxt   = r_deb_cnt;
    case (r_state)
      ST_OK: begin
        if (w_err) begin
          if (DEBOUNCE == 1) begin
            w_state_nxt = ST_ALARM;
            w_deb_nxt   = '0;
          end else begin
            w_state_nxt = ST_PEND;
            w_deb_nxt   = DW'(1);
          end
        end
      end
      ST_PEND: begin
        if (!w_err) begin
          // Any gap in the error restarts the debounce from scratch.
          w_state_nxt = ST_OK;
          w_deb_nxt   = '0;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_nxt = ST_ALARM;
          w_deb_nxt   = '0;
        end else begin
          w_deb_nxt = r_deb_cnt + DW'(1);
        end
      end
      ST_ALARM: begin
        // An acknowledge while the error is still present is ignored.
        if (clear && !w_err) begin
          w_state_nxt = ST_OK;
        end
      end
      default: begin
        w_state_nxt = ST_OK;
        w_deb_nxt   = '0;
      end
    endcase
  end

  assign w_enter = (w_state_nxt == ST_ALARM) && (r_state != ST_ALARM);

  // State, alarm flags and event counter
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= ST_OK;
      r_deb_cnt <= '0;
      r_alarm   <= 1'b0;
      r_pulse   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_deb_cnt <= w_deb_nxt;
      r_alarm   <= (w_state_nxt == ST_ALARM);
      r_pulse   <= w_enter;
      // Saturate at all-ones rather than wrapping.
      if (w_enter && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign error_now   = w_err;
  assign alarm       = r_alarm;
  assign alarm_pulse = r_pulse;
  assign err_count   = r_cnt;
  assign state       = r_state;

endmodule

// File: tb/tb_sensor_alarm_monitor.sv
// Testbench for sensor_alarm_monitor: table of per-cycle vectors on the default instance plus directed corner-case sequences.
// Latency: each vector is applied after one edge and its outputs are checked 1 time unit after the next edge.
// Backpressure: not applicable; every wait on the DUT is bounded by a cycle budget.

module tb_sensor_alarm_monitor;

  typedef struct {
    logic [3:0] s;
    logic       clr;
    logic       en;
    logic       al;
    logic       pu;
    logic [7:0] cnt;
    logic [1:0] st;
  } vec_t;

  logic       clk;
  logic       n_rst;

  // Default instance: DEBOUNCE=4, CNT_W=8
  logic [3:0] a_sens;
  logic       a_clr;
  logic       a_en, a_al, a_pu;
  logic [7:0] a_cnt;
  logic [1:0] a_st;

  // Saturation instance: CNT_W=2
  logic [3:0] b_sens;
  logic       b_clr;
  logic       b_en, b_al, b_pu;
  logic [1:0] b_cnt;
  logic [1:0] b_st;

  // Minimum-debounce instance: DEBOUNCE=1
  logic [3:0] c_sens;
  logic       c_clr;
  logic       c_en, c_al, c_pu;
  logic [7:0] c_cnt;
  logic [1:0] c_st;

  int n_chk;
  int n_fail;

  vec_t tv[$];

  sensor_alarm_monitor #(.DEBOUNCE(4), .CNT_W(8)) u_a (
    .clk(clk), .n_rst(n_rst), .sensors(a_sens), .clear(a_clr),
    .error_now(a_en), .alarm(a_al), .alarm_pulse(a_pu), .err_count(a_cnt), .state(a_st)
  );

  sensor_alarm_monitor #(.DEBOUNCE(4), .CNT_W(2)) u_b (
    .clk(clk), .n_rst(n_rst), .sensors(b_sens), .clear(b_clr),
    .error_now(b_en), .alarm(b_al), .alarm_pulse(b_pu), .err_count(b_cnt), .state(b_st)
  );

  sensor_alarm_monitor #(.DEBOUNCE(1), .CNT_W(8)) u_c (
    .clk(clk), .n_rst(n_rst), .sensors(c_sens), .clear(c_clr),
    .error_now(c_en), .alarm(c_al), .alarm_pulse(c_pu), .err_count(c_cnt), .state(c_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] s, input logic clr, input logic en, input logic al,
                     input logic pu, input logic [7:0] cnt, input logic [1:0] st);
    vec_t v;
    v.s = s; v.clr = clr; v.en = en; v.al = al; v.pu = pu; v.cnt = cnt; v.st = st;
    tv.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_sat[5];
    int n;
    exp_sat = '{1, 2, 3, 3, 3};
    n_chk  = 0;
    n_fail = 0;

    // Vector table: inputs applied before an edge, outputs expected after it.
    // Idle after reset
    for (int i = 0; i < 10; i++) add(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00);
    // 0001 held: sampled, then PEND x3, ALARM on the 4th edge after sampling
    add(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 2'b00);
    add(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 2'b01);
    add(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 2'b01);
    add(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 2'b01);
    add(4'b0001, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 2'b10);
    add(4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 2'b10);
    // clear while the error persists is ignored
    add(4'b1010, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 2'b10);
    add(4'b1010, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 2'b10);
    // error gone, no clear: alarm is sticky
    add(4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 2'b10);
    add(4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 2'b10);
    // error gone with clear: back to OK
    add(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 2'b00);
    add(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 2'b00);
    // 0110 x3, gap, 0110 x3: the gap restarts debounce, no alarm
    add(4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 2'b00);
    add(4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 2'b01);
    add(4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 2'b01);
    add(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 2'b01);
    add(4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 2'b00);
    add(4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 2'b01);
    add(4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 2'b01);
    add(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 2'b01);
    add(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 2'b00);
    // Second alarm with clear held during PEND (no effect): new pulse, count 2
    add(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 2'b00);
    add(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 2'b01);
    add(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 2'b01);
    add(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 2'b01);
    add(4'b0001, 1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 2'b10);
    add(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2, 2'b10);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 2'b00);

    a_sens = 4'b0000; a_clr = 1'b0;
    b_sens = 4'b0000; b_clr = 1'b0;
    c_sens = 4'b0000; c_clr = 1'b0;
    n_rst  = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst.error_now",   int'(a_en),  0);
    chk("rst.alarm",       int'(a_al),  0);
    chk("rst.alarm_pulse", int'(a_pu),  0);
    chk("rst.err_count",   int'(a_cnt), 0);
    chk("rst.state",       int'(a_st),  0);
    n_rst = 1'b1;

    foreach (tv[i]) begin
      a_sens = tv[i].s;
      a_clr  = tv[i].clr;
      tick();
      chk($sformatf("v%0d.error_now", i),   int'(a_en),  int'(tv[i].en));
      chk($sformatf("v%0d.alarm", i),       int'(a_al),  int'(tv[i].al));
      chk($sformatf("v%0d.alarm_pulse", i), int'(a_pu),  int'(tv[i].pu));
      chk($sformatf("v%0d.err_count", i),   int'(a_cnt), int'(tv[i].cnt));
      chk($sformatf("v%0d.state", i),       int'(a_st),  int'(tv[i].st));
    end
    a_sens = 4'b0000;
    a_clr  = 1'b0;

    // CNT_W=2: five alarm/clear rounds, count saturates at 3
    for (int k = 0; k < 5; k++) begin
      b_sens = 4'b0001;
      b_clr  = 1'b0;
      n = 0;
      while (b_al !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      chk($sformatf("sat%0d.alarm", k), int'(b_al), 1);
      chk($sformatf("sat%0d.pulse", k), int'(b_pu), 1);
      chk($sformatf("sat%0d.count", k), int'(b_cnt), exp_sat[k]);
      b_sens = 4'b0000;
      b_clr  = 1'b1;
      n = 0;
      while (b_st !== 2'b00 && n < 10) begin
        tick();
        n++;
      end
      chk($sformatf("sat%0d.cleared", k), int'(b_st), 0);
      b_clr = 1'b0;
    end

    // DEBOUNCE=1: ALARM one edge after the sampling edge
    c_sens = 4'b0001;
    tick();
    chk("deb1.sample.error_now", int'(c_en), 1);
    chk("deb1.sample.state",     int'(c_st), 0);
    tick();
    chk("deb1.alarm",     int'(c_al),  1);
    chk("deb1.pulse",     int'(c_pu),  1);
    chk("deb1.err_count", int'(c_cnt), 1);
    chk("deb1.state",     int'(c_st),  2);
    tick();
    chk("deb1.pulse_drop", int'(c_pu), 0);

    // Async reset while the default instance is mid-PEND
    a_sens = 4'b1010;
    tick();
    tick();
    tick();
    chk("arst.pre.state", int'(a_st), 1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst.error_now",   int'(a_en),  0);
    chk("arst.alarm",       int'(a_al),  0);
    chk("arst.alarm_pulse", int'(a_pu),  0);
    chk("arst.err_count",   int'(a_cnt), 0);
    chk("arst.state",       int'(a_st),  0);
    chk("arst.c.err_count", int'(c_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
